// File: rtl/sm_trace_uart.sv
// sm_trace_uart: trace port for the schoolMIPS core.
// Buffers {pc, instr} samples in a small FIFO and sends each one as a 9-byte
// 8N1 UART frame: 0xA5, pc (MSB byte first), instr (MSB byte first).
module sm_trace_uart #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trace_valid,
  input  logic [31:0]            trace_pc,
  input  logic [31:0]            trace_instr,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(BAUD_DIV);

  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [CW-1:0] BaudLast  = CW'(BAUD_DIV - 1);
  localparam logic [7:0]    SyncByte  = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Input capture stage
  logic        in_valid_q;
  logic [63:0] in_data_q;

  // FIFO state
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          overflow_q;
  logic          push;
  logic          pop;

  // Transmitter state
  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [3:0]    byte_q;
  logic [63:0]   frame_q;
  logic          tx_q;
  logic          busy_q;
  logic [7:0]    cur_byte;
  logic          baud_last;

  // A sample offered at edge N is registered here and lands in the FIFO at N+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= trace_valid;
    end
    in_data_q <= {trace_pc, trace_instr};
  end

  // Pop only from IDLE; a write into a full FIFO is still taken if a pop frees a slot.
  assign pop  = (state_q == StIdle) && (level_q != '0);
  assign push = in_valid_q && ((level_q < LevelFull) || pop);

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      if (in_valid_q && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_data_q;
    end
  end

  // Byte currently on the wire: sync byte first, then the frame register MSB-first.
  always_comb begin
    cur_byte = SyncByte;
    case (byte_q)
      4'd1:    cur_byte = frame_q[63:56];
      4'd2:    cur_byte = frame_q[55:48];
      4'd3:    cur_byte = frame_q[47:40];
      4'd4:    cur_byte = frame_q[39:32];
      4'd5:    cur_byte = frame_q[31:24];
      4'd6:    cur_byte = frame_q[23:16];
      4'd7:    cur_byte = frame_q[15:8];
      4'd8:    cur_byte = frame_q[7:0];
      default: cur_byte = SyncByte;
    endcase
  end

  assign baud_last = (baud_q == BaudLast);

  // Transmitter FSM; uart_tx and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (pop) begin
            frame_q <= mem_q[rd_ptr_q];
            byte_q  <= '0;
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
            tx_q    <= cur_byte[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            if (byte_q == 4'd8) begin
              // Frame done; one IDLE cycle follows before any next start bit.
              state_q <= StIdle;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              byte_q  <= byte_q + 4'd1;
              state_q <= StStart;
              tx_q    <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign level    = level_q;

endmodule

// File: doc/sm_trace_uart.md
# sm_trace_uart

Hardware trace port for the schoolMIPS core. It sits downstream of `sm_top` and takes the per-cycle PC/instruction pair that the simulation bench prints to the console. It buffers these pairs in a small FIFO and serialises each one as a fixed 9-byte UART frame, so the same execution trace is available from an FPGA board without a simulator.

## Interface

**Parameters**
- `DEPTH`, default 8: FIFO entries. Must be a power of 2 and ≥ 2.
- `BAUD_DIV`, default 434: clk cycles per UART bit. Must be ≥ 2.

**Ports**
- `clk`, input, 1: system clock; the only clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `trace_valid`, input, 1: one trace sample is offered this cycle.
- `trace_pc`, input, 32: word PC of the sample.
- `trace_instr`, input, 32: instruction word of the sample.
- `uart_tx`, output, 1: serial output, 8N1, LSB first, idles high. Registered.
- `busy`, output, 1: transmitter is not in IDLE.
- `overflow`, output, 1: sticky flag; a sample was dropped because the FIFO was full.
- `level`, output, $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation

**FIFO**
- Entry is 64 bits: {pc, instr}.
- Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally.
- `level` is a separate counter.
- Write is accepted when `trace_valid && (level < DEPTH || pop)`.
  - Simultaneous write and pop when full is accepted; `level` stays at DEPTH.
- Write is refused when `trace_valid` is high, the FIFO is full and there is no pop. The sample is dropped and `overflow` is set to 1 until reset.
- Simultaneous write and pop when non-full leaves `level` unchanged.
- `pop` is asserted only in IDLE with `level != 0`.

**Frame format**
- 9 bytes in this order: 0xA5, pc[31:24], pc[23:16], pc[15:8], pc[7:0], instr[31:24], instr[23:16], instr[15:8], instr[7:0].
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1).

**Transmitter FSM**
- IDLE
  - `uart_tx`=1.
  - If `level != 0`: pop, load the 64-bit entry into the frame register, byte_cnt=0, go to START.
- START
  - `uart_tx`=0 for BAUD_DIV cycles, then go to DATA with bit_cnt=0.
- DATA
  - `uart_tx` = current byte[bit_cnt] for BAUD_DIV cycles per bit.
  - After bit 7, go to STOP.
- STOP
  - `uart_tx`=1 for BAUD_DIV cycles.
  - If byte_cnt < 8: byte_cnt+1, go to START. There is no gap between bytes.
  - If byte_cnt = 8: go to IDLE.
- The current byte is 0xA5 when byte_cnt=0; otherwise it is frame register bits [63-8*(byte_cnt-1) -: 8].
- The baud counter runs 0..BAUD_DIV-1. It resets on every state or bit change.

**Reset**
- Reset forces: `uart_tx`=1, `busy`=0, `overflow`=0, `level`=0, both pointers 0, FSM in IDLE.
- Reset mid-frame truncates the frame immediately; `uart_tx` is high on the first cycle after reset.
- FIFO contents are discarded; the storage array itself need not be reset.
- `trace_valid` is ignored while `rst_n`=0.

## Timing

- **Sample to FIFO:** `trace_valid` sampled at edge N makes the entry visible at edge N+1 (`level` increments).
- **Pop:** with the transmitter idle, pop occurs in the cycle after N+1. `uart_tx` falls at edge N+2 and `busy` rises at edge N+2.
- **Bit length:** every bit is exactly BAUD_DIV cycles.
- **Frame length:** one frame is 90·BAUD_DIV cycles from the start-bit falling edge to the end of the last stop bit.
- **Back-to-back frames:** there is exactly 1 IDLE cycle between the end of a frame's last stop bit and the next start bit. `busy` is low for that cycle.
- **Throughput:** one sample per (90·BAUD_DIV+1) cycles sustained. Sustained trace rate above that overflows the FIFO by design; the user must slow the CPU through `clkDevide`.

## Test plan

Run with BAUD_DIV=4 and DEPTH=4. The bench includes a UART receiver model that samples mid-bit.

1. **Single sample.** Drive pc=0x00000003, instr=0x24020005 for one cycle.
   - Receiver decodes A5 00 00 00 03 24 02 00 05.
   - `uart_tx` falls exactly 2 cycles after the valid edge.
   - Frame lasts 360 cycles; `busy` then drops; `overflow`=0.
2. **Burst fill.** Drive 5 consecutive valid cycles with pc=1..5 starting with the transmitter idle.
   - Entry 1 is popped immediately, so all 5 are stored: `level` peaks at 4 and `overflow` stays 0.
   - 5 frames are received in order, pc=1..5, each separated by exactly 1 idle cycle.
3. **Overflow.** Drive 7 consecutive valid cycles.
   - The 6th and 7th samples are dropped and `overflow` rises on the edge after the 6th.
   - Only pc=1..5 are received.
   - `overflow` stays 1 after the FIFO drains.
4. **Full plus pop.** Hold the FIFO at `level`=4 and assert `trace_valid` in the IDLE pop cycle.
   - The write is accepted, `level` stays 4 and `overflow` stays 0.
5. **Reset mid-frame.** Assert `rst_n`=0 for 1 cycle during byte 3 of a frame while `level`=2.
   - Next cycle: `uart_tx`=1, `level`=0, `busy`=0, `overflow`=0.
   - No further bytes are emitted until a new sample arrives.
6. **Pointer wrap.** Send 10 samples spaced 400 cycles apart.
   - All 10 are decoded correctly, showing the pointers wrap past DEPTH.
   - `level` never exceeds 1.
